sram_1rw1r_param: RTL and testbench

Parametrised single-clock 1RW+1R SRAM with byte-granular write mask, registered hold-until-next-read outputs, and a power-on clear sequencer. It is the successor to the fixed 32x512 dual-clock macro and backs the instruction/data cache tag and data arrays. It gives the cache controllers one uniform, synthesisable memory with defined post-reset contents and defined same-cycle port collision behaviour.

---
 rtl/sram_1rw1r_param.sv | 135 +++++++++++++
 tb/tb_sram_1rw1r_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: single-clock 1RW + 1R SRAM with byte write mask,
// hold-until-next-read output registers and a power-on clear sequencer.
//
// Optional feature macro: SRAM_BYPASS_EN
//   defined   -> same-cycle port 0 write / port 1 read at the same address
//                returns the merged (written) word on p1_dout (write-first).
//   undefined -> port 1 returns the previously stored word (read-first),
//                the array still takes the write.
//
// DATA_WIDTH must be an integer multiple of BYTE_WIDTH.

module sram_1rw1r_param #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 9,
   parameter int unsigned           BYTE_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               ready,
   input  logic                               p0_en,
   input  logic                               p0_we,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   p0_wmask,
   input  logic [ADDR_WIDTH-1:0]              p0_addr,
   input  logic [DATA_WIDTH-1:0]              p0_din,
   output logic [DATA_WIDTH-1:0]              p0_dout,
   input  logic                               p1_en,
   input  logic [ADDR_WIDTH-1:0]              p1_addr,
   output logic [DATA_WIDTH-1:0]              p1_dout
);

   localparam int unsigned NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  serve;
   logic                  wr_en;
   logic                  rd0_en;
   logic                  rd1_en;

   // Storage array; deliberately not reset, contents come from the clear walk
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Port requests only count once the clear walk has finished
   assign serve  = (state == IDLE);
   assign wr_en  = serve & p0_en & p0_we;
   assign rd0_en = serve & p0_en & ~p0_we;
   assign rd1_en = serve & p1_en;

`ifdef SRAM_BYPASS_EN
   logic [DATA_WIDTH-1:0] bit_mask;
   logic [DATA_WIDTH-1:0] merged;
   logic                  p1_hit;

   // Expand the byte mask to a bit mask for the write-first bypass word
   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < NUM_WMASKS; i++) begin
         bit_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{p0_wmask[i]}};
      end
   end

   assign merged = (mem[p0_addr] & ~bit_mask) | (p0_din & bit_mask);
   assign p1_hit = wr_en & p1_en & (p1_addr == p0_addr);
`endif

   // Clear sequencer: walks every address once after reset, then idles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
               if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            IDLE: begin
               ready <= 1'b1;
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Array writes: clear value during the walk, byte-masked port 0 writes after
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) begin
         mem[clr_cnt] <= CLEAR_VALUE;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (p0_wmask[i]) begin
               mem[p0_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= p0_din[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Port 0 read register; holds its value until the next port 0 read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_dout <= '0;
      end else if (rd0_en) begin
         p0_dout <= mem[p0_addr];
      end
   end

   // Port 1 read register; collision result depends on the bypass build
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_dout <= '0;
      end else if (rd1_en) begin
`ifdef SRAM_BYPASS_EN
         p1_dout <= p1_hit ? merged : mem[p1_addr];
`else
         p1_dout <= mem[p1_addr];
`endif
      end
   end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Testbench for sram_1rw1r_param (default parameters: 32-bit words, 512 deep).
// Reference model: plain word array plus expected read registers, updated
// once per clock from the currently driven inputs.

module tb_sram_1rw1r_param;

   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready;
   logic        p0_en, p0_we;
   logic [3:0]  p0_wmask;
   logic [8:0]  p0_addr;
   logic [31:0] p0_din;
   logic [31:0] p0_dout;
   logic        p1_en;
   logic [8:0]  p1_addr;
   logic [31:0] p1_dout;

   int total  = 0;
   int passed = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] p0_exp;
   logic [31:0] p1_exp;
   int          clr_cnt;

   sram_1rw1r_param dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .p0_en    (p0_en),
      .p0_we    (p0_we),
      .p0_wmask (p0_wmask),
      .p0_addr  (p0_addr),
      .p0_din   (p0_din),
      .p0_dout  (p0_dout),
      .p1_en    (p1_en),
      .p1_addr  (p1_addr),
      .p1_dout  (p1_dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ready"}, {31'd0, ready}, {31'd0, (clr_cnt >= DEPTH)});
      check({tag, ".p0"}, p0_dout, p0_exp);
      check({tag, ".p1"}, p1_dout, p1_exp);
   endtask

   task automatic idle();
      p0_en = 0; p0_we = 0; p0_wmask = '0; p0_addr = '0; p0_din = '0;
      p1_en = 0; p1_addr = '0;
   endtask

   task automatic model_reset();
      clr_cnt = 0;
      p0_exp  = '0;
      p1_exp  = '0;
   endtask

   // Advance the model by one clock using the inputs currently driven, then clock the DUT
   task automatic tick();
      logic [31:0] nw;
      if (clr_cnt >= DEPTH) begin
         if (p0_en && !p0_we) p0_exp = mem_m[p0_addr];
         if (p1_en) p1_exp = mem_m[p1_addr];
         if (p0_en && p0_we) begin
            nw = mem_m[p0_addr];
            for (int b = 0; b < 4; b++)
               if (p0_wmask[b]) nw[b*8 +: 8] = p0_din[b*8 +: 8];
`ifdef SRAM_BYPASS_EN
            if (p1_en && p1_addr == p0_addr) p1_exp = nw;
`endif
            mem_m[p0_addr] = nw;
         end
      end else begin
         clr_cnt++;
         if (clr_cnt == DEPTH)
            for (int a = 0; a < DEPTH; a++) mem_m[a] = 32'h0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
      idle();
      p0_en = 1; p0_we = 1; p0_addr = a; p0_din = d; p0_wmask = m;
      tick();
      idle();
   endtask

   task automatic randomize_inputs(input int amax);
      p0_en    = 1'($urandom);
      p0_we    = 1'($urandom);
      p0_wmask = 4'($urandom);
      p0_addr  = 9'($urandom_range(0, amax));
      p0_din   = $urandom;
      p1_en    = 1'($urandom);
      p1_addr  = 9'($urandom_range(0, amax));
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");

      // Clear walk with random traffic that must be ignored
      rst = 1'b0;
      for (int c = 1; c <= DEPTH; c++) begin
         randomize_inputs(DEPTH - 1);
         tick();
         check_all("clear1");
      end
      idle();

      // Every word reads back as the clear value on both ports
      for (int i = 0; i < DEPTH; i++) begin
         p0_en = 1; p0_we = 0; p0_addr = 9'(i);
         p1_en = 1; p1_addr = 9'(DEPTH - 1 - i);
         tick();
         check("sweep.p0", p0_dout, p0_exp);
         check("sweep.p1", p1_dout, p1_exp);
      end
      idle();

      // Byte-mask merge
      wr(9'd5, 32'hDEADBEEF, 4'hF);
      wr(9'd5, 32'h11223344, 4'h5);
      p0_en = 1; p0_we = 0; p0_addr = 9'd5;
      tick();
      check("mask_merge", p0_dout, 32'hDE22BE44);
      check("mask_merge.model", p0_dout, p0_exp);
      idle();

      // Zero mask write is a no-op
      wr(9'd5, 32'h00000000, 4'h0);
      p1_en = 1; p1_addr = 9'd5;
      tick();
      check("p1_read5", p1_dout, 32'hDE22BE44);
      idle();

      // Port 1 holds while disabled and addr 5 is rewritten
      for (int k = 0; k < 10; k++) begin
         p0_en = 1; p0_we = 1; p0_addr = 9'd5; p0_din = $urandom; p0_wmask = 4'hF;
         p1_en = 0; p1_addr = 9'($urandom_range(0, DEPTH - 1));
         tick();
         check("p1_hold", p1_dout, 32'hDE22BE44);
      end
      idle();
      p1_en = 1; p1_addr = 9'd5;
      tick();
      check("p1_reread", p1_dout, p1_exp);
      idle();

      // Same-cycle write / read collision
      wr(9'd7, 32'h12345678, 4'hF);
      p0_en = 1; p0_we = 1; p0_addr = 9'd7; p0_din = 32'hAABBCCDD; p0_wmask = 4'h3;
      p1_en = 1; p1_addr = 9'd7;
      tick();
`ifdef SRAM_BYPASS_EN
      check("collide", p1_dout, 32'h1234CCDD);
`else
      check("collide", p1_dout, 32'h12345678);
`endif
      check("collide.model", p1_dout, p1_exp);
      idle();
      p1_en = 1; p1_addr = 9'd7;
      tick();
      check("collide_after", p1_dout, 32'h1234CCDD);
      idle();

      // Random traffic over a narrow address window to force collisions
      for (int k = 0; k < 400; k++) begin
         randomize_inputs(15);
         tick();
         check_all("rand");
      end
      idle();

      // Reset in IDLE, then again mid-clear
      wr(9'd3, 32'hFFFFFFFF, 4'hF);
      p0_en = 1; p0_we = 0; p0_addr = 9'd3;
      tick();
      check("addr3_set", p0_dout, 32'hFFFFFFFF);
      idle();
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_idle.ready", {31'd0, ready}, 32'd0);
      check("rst_idle.p0", p0_dout, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 200; c++) tick();
      check_all("clear2");
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_mid.ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 1; c <= DEPTH; c++) begin
         randomize_inputs(7);
         tick();
         check_all("clear3");
      end
      idle();
      p0_en = 1; p0_we = 0; p0_addr = 9'd3;
      p1_en = 1; p1_addr = 9'd3;
      tick();
      check("addr3_cleared.p0", p0_dout, 32'd0);
      check("addr3_cleared.p1", p1_dout, 32'd0);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
